// File: rtl/digit_entry_ctrl.sv
// rtl/digit_entry_ctrl.sv - debounced three-button digit editor with cursor, auto-repeat, carry and parallel load
module digit_entry_ctrl #(
  parameter int DIGITS       = 4,
  parameter int RADIX        = 10,
  parameter int DB_CYCLES    = 50000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int CARRY        = 0,
  localparam int SELW        = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  inc_n,
  input  logic                  dec_n,
  input  logic                  nxt_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   digits,
  output logic [SELW-1:0]       sel,
  output logic                  editing,
  output logic                  chg
);

  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DLY = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_RT  = RPT_W'(REPEAT_RATE);
  localparam logic [3:0] DIG_TOP = 4'(RADIX - 1);
  localparam logic [4:0] RADIX_V = 5'(RADIX);
  localparam logic [SELW-1:0] SEL_LAST = SELW'(DIGITS);

  typedef enum logic [1:0] {RPT_IDLE, RPT_WAIT, RPT_RUN} rpt_state_t;

  // Button index: 0 = inc, 1 = dec, 2 = nxt
  logic [2:0]      raw;
  logic [2:0]      sync1;
  logic [2:0]      sync2;
  logic [2:0]      stab;
  logic [2:0]      press;
  logic [DB_W-1:0] db_cnt [3];
  logic [1:0]      rpt;

  assign raw = {nxt_n, dec_n, inc_n};

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync1 <= '1;
      sync2 <= '1;
      stab  <= '1;
      press <= '0;
      for (int b = 0; b < 3; b++) db_cnt[b] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= '0;
      for (int b = 0; b < 3; b++) begin
        if (sync2[b] == stab[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          stab[b]   <= sync2[b];
          db_cnt[b] <= '0;
          press[b]  <= ~sync2[b];
        end else begin
          db_cnt[b] <= db_cnt[b] + DB_W'(1);
        end
      end
    end
  end

  // Hold-to-repeat for inc and dec; the counter restarts at 1 on every fire
  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_rpt
      rpt_state_t       state;
      rpt_state_t       state_nx;
      logic [RPT_W-1:0] cnt;
      logic [RPT_W-1:0] cnt_nx;
      logic             fire;

      always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
          state <= RPT_IDLE;
          cnt   <= '0;
        end else begin
          state <= state_nx;
          cnt   <= cnt_nx;
        end
      end

      always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        fire     = 1'b0;
        if (REPEAT_DELAY == 0 || stab[g]) begin
          state_nx = RPT_IDLE;
          cnt_nx   = '0;
        end else if (press[g]) begin
          state_nx = RPT_WAIT;
          cnt_nx   = RPT_W'(1);
        end else begin
          case (state)
            RPT_WAIT: begin
              if (cnt == RPT_DLY) begin
                fire     = 1'b1;
                state_nx = RPT_RUN;
                cnt_nx   = RPT_W'(1);
              end else begin
                cnt_nx = cnt + RPT_W'(1);
              end
            end
            RPT_RUN: begin
              if (cnt == RPT_RT) begin
                fire   = 1'b1;
                cnt_nx = RPT_W'(1);
              end else begin
                cnt_nx = cnt + RPT_W'(1);
              end
            end
            default: ;
          endcase
        end
      end

      assign rpt[g] = fire;
    end
  endgenerate

  logic                ev_inc;
  logic                ev_dec;
  logic                ev_nxt;
  logic [4*DIGITS-1:0] dig_q;
  logic [4*DIGITS-1:0] dig_nx;
  logic [SELW-1:0]     sel_q;
  logic [SELW-1:0]     sel_nx;
  logic                rip;
  logic [3:0]          nib;

  assign ev_inc = press[0] | rpt[0];
  assign ev_dec = press[1] | rpt[1];
  assign ev_nxt = press[2];

  // rip marks "this digit still has to absorb a +1/-1"; it starts at the cursor digit
  always_comb begin
    dig_nx = dig_q;
    sel_nx = sel_q;
    rip    = 1'b0;
    nib    = '0;
    if (load) begin
      for (int k = 0; k < DIGITS; k++) begin
        nib = load_val[4*k +: 4];
        dig_nx[4*k +: 4] = ({1'b0, nib} < RADIX_V) ? nib : 4'd0;
      end
      sel_nx = '0;
    end else begin
      if (sel_q != '0 && (ev_inc ^ ev_dec)) begin
        for (int k = 0; k < DIGITS; k++) begin
          nib = dig_q[4*k +: 4];
          if (k == int'(sel_q) - 1) rip = 1'b1;
          if (rip) begin
            if (ev_inc) begin
              if (nib == DIG_TOP) begin
                dig_nx[4*k +: 4] = 4'd0;
              end else begin
                dig_nx[4*k +: 4] = nib + 4'd1;
                rip = 1'b0;
              end
            end else begin
              if (nib == 4'd0) begin
                dig_nx[4*k +: 4] = DIG_TOP;
              end else begin
                dig_nx[4*k +: 4] = nib - 4'd1;
                rip = 1'b0;
              end
            end
            if (CARRY == 0) rip = 1'b0;
          end
        end
      end
      if (ev_nxt) sel_nx = (sel_q == SEL_LAST) ? '0 : sel_q + SELW'(1);
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      dig_q   <= '0;
      sel_q   <= '0;
      chg     <= 1'b0;
      editing <= 1'b0;
    end else begin
      dig_q   <= dig_nx;
      sel_q   <= sel_nx;
      chg     <= (dig_nx != dig_q);
      editing <= (sel_nx != '0);
    end
  end

  assign digits = dig_q;
  assign sel    = sel_q;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// tb/tb_digit_entry_ctrl.sv - random and directed bench for digit_entry_ctrl against a digit-value reference model
module tb_digit_entry_ctrl;
  localparam int DIGITS = 4;
  localparam int RADIX  = 10;
  localparam int DB     = 4;
  localparam int RD     = 20;
  localparam int RR     = 5;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        inc_n = 1'b1;
  logic        dec_n = 1'b1;
  logic        nxt_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] digits0, digits1;
  logic [2:0]  sel0, sel1;
  logic        editing0, editing1, chg0, chg1;

  always #5 clk = ~clk;

  digit_entry_ctrl #(.DIGITS(DIGITS), .RADIX(RADIX), .DB_CYCLES(DB), .REPEAT_DELAY(RD),
                     .REPEAT_RATE(RR), .CARRY(0)) u_dut0 (
    .clk(clk), .nRst(nRst), .inc_n(inc_n), .dec_n(dec_n), .nxt_n(nxt_n), .load(load),
    .load_val(load_val), .digits(digits0), .sel(sel0), .editing(editing0), .chg(chg0));

  digit_entry_ctrl #(.DIGITS(DIGITS), .RADIX(RADIX), .DB_CYCLES(DB), .REPEAT_DELAY(RD),
                     .REPEAT_RATE(RR), .CARRY(1)) u_dut1 (
    .clk(clk), .nRst(nRst), .inc_n(inc_n), .dec_n(dec_n), .nxt_n(nxt_n), .load(load),
    .load_val(load_val), .digits(digits1), .sel(sel1), .editing(editing1), .chg(chg1));

  int n_checks = 0;
  int n_errors = 0;
  int chg_seen = 0;

  // Reference state: digit values per carry mode, cursor, and button acceptance bookkeeping
  int m_dig [2][DIGITS];
  int m_sel;
  bit m_chg [2];
  bit m_r1 [3];
  bit m_r2 [3];
  bit m_stab [3];
  int m_run [3];
  bit m_pend [3];
  bit m_rpt_on [2];
  int m_pu [2];
  int m_n = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < DIGITS; k++) m_dig[c][k] = 0;
      m_chg[c] = 0;
      m_rpt_on[c] = 0;
      m_pu[c] = 0;
    end
    m_sel = 0;
    for (int b = 0; b < 3; b++) begin
      m_r1[b] = 1; m_r2[b] = 1; m_stab[b] = 1; m_run[b] = 0; m_pend[b] = 0;
    end
  endfunction

  function automatic logic [15:0] m_pack(input int c);
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < DIGITS; k++) v[4*k +: 4] = 4'(m_dig[c][k]);
    return v;
  endfunction

  function automatic void model_edge();
    bit raw [3];
    bit ev [3];
    bit lvl;
    int diff, t, step, span, v, nib;
    int old [DIGITS];
    raw[0] = inc_n; raw[1] = dec_n; raw[2] = nxt_n;
    m_n++;
    if (!nRst) begin
      model_reset();
      return;
    end
    for (int b = 0; b < 3; b++) begin
      ev[b] = m_pend[b];
      m_pend[b] = 0;
    end
    for (int b = 0; b < 2; b++) begin
      if (m_rpt_on[b]) begin
        diff = m_n - m_pu[b];
        if (diff == RD || (diff > RD && (diff - RD) % RR == 0)) ev[b] = 1;
      end
    end
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < DIGITS; k++) old[k] = m_dig[c][k];
      if (load) begin
        for (int k = 0; k < DIGITS; k++) begin
          nib = (int'(load_val) >> (4*k)) & 15;
          m_dig[c][k] = (nib < RADIX) ? nib : 0;
        end
      end else if (m_sel != 0 && (ev[0] != ev[1])) begin
        t = m_sel - 1;
        step = ev[0] ? 1 : -1;
        if (c == 0) begin
          m_dig[c][t] = (m_dig[c][t] + step + RADIX) % RADIX;
        end else begin
          span = 1; v = 0;
          for (int k = t; k < DIGITS; k++) begin
            v += m_dig[c][k] * span;
            span *= RADIX;
          end
          v = (v + step + span) % span;
          for (int k = t; k < DIGITS; k++) begin
            m_dig[c][k] = v % RADIX;
            v = v / RADIX;
          end
        end
      end
      m_chg[c] = 0;
      for (int k = 0; k < DIGITS; k++) if (old[k] != m_dig[c][k]) m_chg[c] = 1;
    end
    if (load) m_sel = 0;
    else if (ev[2]) m_sel = (m_sel + 1) % (DIGITS + 1);
    // Debounce sees the raw level from two edges earlier
    for (int b = 0; b < 3; b++) begin
      lvl = m_r2[b];
      m_r2[b] = m_r1[b];
      m_r1[b] = raw[b];
      if (lvl != m_stab[b]) begin
        m_run[b]++;
        if (m_run[b] == DB) begin
          m_stab[b] = lvl;
          m_run[b] = 0;
          if (!lvl) begin
            m_pend[b] = 1;
            if (b < 2) begin
              m_rpt_on[b] = 1;
              m_pu[b] = m_n + 1;
            end
          end else if (b < 2) begin
            m_rpt_on[b] = 0;
          end
        end
      end else begin
        m_run[b] = 0;
      end
    end
  endfunction

  task automatic compare_all();
    check_val("dig_c0", 32'(digits0), 32'(m_pack(0)));
    check_val("dig_c1", 32'(digits1), 32'(m_pack(1)));
    check_val("sel_c0", 32'(sel0), 32'(m_sel));
    check_val("sel_c1", 32'(sel1), 32'(m_sel));
    check_val("edit_c0", 32'(editing0), 32'(m_sel != 0));
    check_val("edit_c1", 32'(editing1), 32'(m_sel != 0));
    check_val("chg_c0", 32'(chg0), 32'(m_chg[0]));
    check_val("chg_c1", 32'(chg1), 32'(m_chg[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (chg0) chg_seen++;
    compare_all();
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       inc_n = v;
      1:       dec_n = v;
      default: nxt_n = v;
    endcase
  endtask

  task automatic hold(input int b, input int n_low, input int n_high);
    set_btn(b, 1'b0);
    repeat (n_low) tick();
    set_btn(b, 1'b1);
    repeat (n_high) tick();
  endtask

  task automatic do_load(input logic [15:0] v);
    load_val = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic mid_reset();
    #2;
    nRst = 1'b0;
    model_reset();
    #1;
    compare_all();
  endtask

  int lvl_r [3];
  int left_r [3];

  initial begin
    model_reset();
    repeat (2) tick();
    nRst = 1'b1;
    repeat (3) tick();
    check_val("rst_dig", 32'(digits0), 32'h0);
    check_val("rst_sel", 32'(sel0), 32'h0);
    check_val("rst_chg", 32'(chg0), 32'h0);

    // nxt latency: sel moves on the 7th edge counting the first low sample
    set_btn(2, 1'b0);
    repeat (6) tick();
    check_val("nxt_pre", 32'(sel0), 32'd0);
    tick();
    check_val("nxt_lat", 32'(sel0), 32'd1);
    check_val("nxt_edit", 32'(editing0), 32'd1);
    tick();
    set_btn(2, 1'b1);
    repeat (10) tick();
    for (int i = 1; i <= 4; i++) begin
      hold(2, 8, 10);
      check_val("nxt_walk", 32'(sel0), 32'((i + 1) % 5));
    end
    check_val("nxt_wrap_edit", 32'(editing0), 32'd0);

    do_load(16'h0009);
    hold(2, 8, 10);
    chg_seen = 0;
    hold(0, 8, 10);
    check_val("inc_wrap_c0", 32'(digits0), 32'h0000);
    check_val("inc_wrap_c1", 32'(digits1), 32'h0010);
    check_val("inc_chg_once", 32'(chg_seen), 32'd1);

    do_load(16'h0999);
    hold(2, 8, 10);
    hold(0, 8, 10);
    check_val("carry_c0", 32'(digits0), 32'h0990);
    check_val("carry_c1", 32'(digits1), 32'h1000);

    do_load(16'h0000);
    hold(2, 8, 10);
    hold(2, 8, 10);
    hold(1, 8, 10);
    check_val("borrow_c0", 32'(digits0), 32'h0090);
    check_val("borrow_c1", 32'(digits1), 32'h9990);

    do_load(16'h0000);
    hold(2, 8, 10);
    chg_seen = 0;
    hold(0, 40, 12);
    check_val("rpt_c0", 32'(digits0), 32'h0005);
    check_val("rpt_c1", 32'(digits1), 32'h0005);
    check_val("rpt_events", 32'(chg_seen), 32'd5);
    hold(1, 3, 10);
    check_val("glitch", 32'(digits0), 32'h0005);

    // load lands on the same edge as an inc press event
    set_btn(0, 1'b0);
    repeat (6) tick();
    load_val = 16'hA123;
    load = 1'b1;
    tick();
    load = 1'b0;
    check_val("load_c0", 32'(digits0), 32'h0123);
    check_val("load_c1", 32'(digits1), 32'h0123);
    check_val("load_sel", 32'(sel0), 32'd0);
    tick();
    set_btn(0, 1'b1);
    repeat (10) tick();
    check_val("load_after", 32'(digits0), 32'h0123);

    hold(2, 8, 10);
    chg_seen = 0;
    inc_n = 1'b0;
    dec_n = 1'b0;
    repeat (8) tick();
    inc_n = 1'b1;
    dec_n = 1'b1;
    repeat (10) tick();
    check_val("incdec_dig", 32'(digits0), 32'h0123);
    check_val("incdec_chg", 32'(chg_seen), 32'd0);

    do_load(16'h0000);
    hold(2, 8, 10);
    set_btn(0, 1'b0);
    repeat (30) tick();
    check_val("pre_rst", 32'(digits0), 32'h0002);
    mid_reset();
    check_val("mid_rst_dig", 32'(digits1), 32'h0000);
    check_val("mid_rst_sel", 32'(sel1), 32'd0);
    repeat (2) tick();
    nRst = 1'b1;
    repeat (12) tick();
    check_val("post_rst_dig", 32'(digits0), 32'h0000);
    check_val("post_rst_sel", 32'(sel0), 32'd0);
    set_btn(0, 1'b1);
    repeat (10) tick();

    for (int b = 0; b < 3; b++) begin
      lvl_r[b] = 1;
      left_r[b] = $urandom_range(1, 30);
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < 3; b++) begin
        if (left_r[b] == 0) begin
          lvl_r[b] = 1 - lvl_r[b];
          left_r[b] = $urandom_range(1, 45);
        end
        left_r[b]--;
        set_btn(b, logic'(lvl_r[b]));
      end
      if ($urandom_range(0, 149) == 0) begin
        load = 1'b1;
        load_val = 16'($urandom);
      end else begin
        load = 1'b0;
      end
      tick();
      if ($urandom_range(0, 999) == 0) begin
        mid_reset();
        tick();
        nRst = 1'b1;
      end
    end
    load = 1'b0;
    inc_n = 1'b1;
    dec_n = 1'b1;
    nxt_n = 1'b1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
